// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's memory-side and decode-side signals.
// master: the fetch stage; slave: the instruction memory / decode environment.
// No logic here, only signal grouping and direction views.
interface if_fetch_if;
  // decode-side control
  logic        hold_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  // instruction memory
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ack_i;
  // decode-side instruction
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [31:0] fetch_cnt_o;

  modport master (
    input  hold_i, jump_en_i, jump_addr_i, imem_rdata_i, imem_ack_i,
    output imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o, fetch_cnt_o
  );

  modport slave (
    output hold_i, jump_en_i, jump_addr_i, imem_rdata_i, imem_ack_i,
    input  imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o, fetch_cnt_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, reads imem over req/ack, hands instructions to decode.
// Latency: ack cycle + 1 clk to inst_o; 1 instr/clk with zero-wait memory.
// Backpressure: hold_i parks one in-flight word in a 1-entry skid and drops req until drained.
// Optional accepted-instruction counter enabled by defining IF_FETCH_CNT_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic      clk,
  input logic      rst_n,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_KILL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;
  logic        valid_q;
  logic [31:0] skid_inst;
  logic [31:0] skid_addr;

  logic [31:0] jump_tgt;
  logic [31:0] pc_inc;
  logic        outstanding;

  // Targets are forced to word alignment; the low two bits of jump_addr_i are ignored.
  assign jump_tgt    = bus.jump_addr_i & ~32'h3;
  assign pc_inc      = pc + 32'd4;
  assign outstanding = req_q & ~bus.imem_ack_i;

  // Fetch FSM: PC, memory request, skid entry and decode-side outputs, all registered.
  // The skid holds data only while in S_FULL, so leaving S_FULL is what empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      inst_q      <= NOP_INST;
      inst_addr_q <= RESET_PC;
      valid_q     <= 1'b0;
      skid_inst   <= NOP_INST;
      skid_addr   <= RESET_PC;
    end else if (bus.jump_en_i && state != S_KILL) begin
      // Redirect wins over hold and over any data returning this cycle.
      pc      <= jump_tgt;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      if (outstanding) begin
        // Memory still owes us a word for the old address: keep req/addr until it arrives.
        state <= S_KILL;
      end else begin
        state  <= S_FETCH;
        req_q  <= 1'b1;
        addr_q <= jump_tgt;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state  <= S_FETCH;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        S_FETCH: begin
          if (bus.imem_ack_i) begin
            pc     <= pc_inc;
            addr_q <= pc_inc;
            if (!bus.hold_i) begin
              inst_q      <= bus.imem_rdata_i;
              inst_addr_q <= pc;
              valid_q     <= 1'b1;
            end else begin
              // Decode is stalled: park the returned word and stop requesting.
              skid_inst <= bus.imem_rdata_i;
              skid_addr <= pc;
              req_q     <= 1'b0;
              state     <= S_FULL;
            end
          end else if (!bus.hold_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (!bus.hold_i) begin
            inst_q      <= skid_inst;
            inst_addr_q <= skid_addr;
            valid_q     <= 1'b1;
            req_q       <= 1'b1;
            addr_q      <= pc;
            state       <= S_FETCH;
          end
        end
        S_KILL: begin
          // Only the PC follows a further jump; the bus stays on the killed address.
          if (bus.jump_en_i) begin
            pc <= jump_tgt;
          end
          if (bus.imem_ack_i) begin
            state  <= S_FETCH;
            req_q  <= 1'b1;
            addr_q <= bus.jump_en_i ? jump_tgt : pc;
          end
        end
      endcase
    end
  end

  assign bus.imem_req_o   = req_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_addr_o  = inst_addr_q;
  assign bus.inst_valid_o = valid_q;

`ifdef IF_FETCH_CNT_EN
  logic [31:0] cnt_q;

  // Count instructions taken by decode; a redirect cycle is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'h0;
    end else if (valid_q && !bus.hold_i && !bus.jump_en_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt_o = cnt_q;
`else
  assign bus.fetch_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized run against a stream model.
// The model tracks only the architectural instruction stream (next expected address,
// data = addr ^ key, accepted count) and the memory handshake rules.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
`ifdef IF_FETCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_next;
  logic [31:0] cnt_exp;
  logic        pend;
  logic [31:0] pend_addr;
  int          wait_cnt;
  int          ack_mode;  // 0: ack at once, 1: random, 2: ack after two wait clocks
  int          accepts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_next = 32'h0;
    cnt_exp  = 32'h0;
    pend     = 1'b0;
    wait_cnt = 0;
    accepts  = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},       32'(bus.imem_req_o),   32'h0);
    check({tag, "_addr"},      bus.imem_addr_o,       32'h0);
    check({tag, "_inst"},      bus.inst_o,            NOP);
    check({tag, "_inst_addr"}, bus.inst_addr_o,       32'h0);
    check({tag, "_valid"},     32'(bus.inst_valid_o), 32'h0);
    check({tag, "_cnt"},       bus.fetch_cnt_o,       32'h0);
  endtask

  // One clock: called at a negedge, drives inputs, checks, returns at the next negedge.
  task automatic step(input logic h, input logic j, input logic [31:0] ja);
    logic a;
    if (pend) begin
      check("req_held_while_waiting",  32'(bus.imem_req_o), 32'h1);
      check("addr_held_while_waiting", bus.imem_addr_o,     pend_addr);
    end
    a = 1'b0;
    if (bus.imem_req_o) begin
      case (ack_mode)
        0:       a = 1'b1;
        1:       a = 1'($urandom_range(1, 0));
        default: a = (wait_cnt >= 2);
      endcase
    end
    wait_cnt = (bus.imem_req_o && !a) ? wait_cnt + 1 : 0;
    bus.imem_ack_i   = a;
    bus.imem_rdata_i = a ? (bus.imem_addr_o ^ KEY) : 32'hDEAD_BEEF;
    bus.hold_i       = h;
    bus.jump_en_i    = j;
    bus.jump_addr_i  = ja;
    #1;
    if (!bus.inst_valid_o) check("nop_when_invalid", bus.inst_o, NOP);
    check("fetch_cnt", bus.fetch_cnt_o, CNT_EN ? cnt_exp : 32'h0);
    if (bus.inst_valid_o && !h) begin
      check("stream_addr", bus.inst_addr_o, exp_next);
      check("stream_data", bus.inst_o, exp_next ^ KEY);
      exp_next = exp_next + 32'd4;
      accepts++;
      if (!j) cnt_exp = cnt_exp + 32'd1;
    end
    if (j) exp_next = ja & ~32'h3;
    pend      = bus.imem_req_o && !a;
    pend_addr = bus.imem_addr_o;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int a0;
    bit seen_new;
    bus.hold_i = 1'b0; bus.jump_en_i = 1'b0; bus.jump_addr_i = 32'h0;
    bus.imem_ack_i = 1'b0; bus.imem_rdata_i = 32'h0;
    ack_mode = 0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory: request one clock after release, then one instruction per clock.
    step(0, 0, 0);
    check("t1_req_after_release", 32'(bus.imem_req_o), 32'h1);
    check("t1_first_addr", bus.imem_addr_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      check("t1_inst_addr", bus.inst_addr_o, 32'(i * 4));
      check("t1_valid", 32'(bus.inst_valid_o), 32'h1);
    end

    // Hold for three clocks while fetching 0x10.
    check("t3_pre_addr", bus.imem_addr_o, 32'h10);
    step(1, 0, 0);
    check("t3_hold1_inst_addr", bus.inst_addr_o, 32'hC);
    check("t3_hold2_req_low", 32'(bus.imem_req_o), 32'h0);
    step(1, 0, 0);
    check("t3_hold2_inst_addr", bus.inst_addr_o, 32'hC);
    check("t3_hold3_req_low", 32'(bus.imem_req_o), 32'h0);
    step(1, 0, 0);
    check("t3_hold3_inst_addr", bus.inst_addr_o, 32'hC);
    step(0, 0, 0);
    check("t3_skid_out", bus.inst_addr_o, 32'h10);
    check("t3_skid_valid", 32'(bus.inst_valid_o), 32'h1);
    step(0, 0, 0);
    check("t3_after_skid", bus.inst_addr_o, 32'h14);

    // Memory answering two clocks late: one valid per three clocks.
    ack_mode = 2;
    v = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      if (bus.inst_valid_o) v++;
    end
    check("t2_valid_count", 32'(v), 32'h2);
    check("t2_next_req_addr", bus.imem_addr_o, 32'h20);

    // Jump while the 0x20 request is still outstanding.
    step(0, 1, 32'h103);
    check("t4_kill_req", 32'(bus.imem_req_o), 32'h1);
    check("t4_kill_addr", bus.imem_addr_o, 32'h20);
    check("t4_kill_valid", 32'(bus.inst_valid_o), 32'h0);
    seen_new = 1'b0;
    for (int n = 0; n < 12 && !bus.inst_valid_o; n++) begin
      step(0, 0, 0);
      if (!seen_new && bus.imem_addr_o != 32'h20) begin
        check("t4_next_req_addr", bus.imem_addr_o, 32'h100);
        seen_new = 1'b1;
      end
    end
    check("t4_valid_seen", 32'(bus.inst_valid_o), 32'h1);
    check("t4_first_inst_addr", bus.inst_addr_o, 32'h100);

    // Jump together with hold while the skid is full; target wraps past 2^32.
    ack_mode = 0;
    step(1, 0, 0);
    check("t5_full_req_low", 32'(bus.imem_req_o), 32'h0);
    step(1, 1, 32'hFFFF_FFFE);
    check("t5_valid_dropped", 32'(bus.inst_valid_o), 32'h0);
    check("t5_req_target", bus.imem_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 0);
    check("t5_inst_at_target", bus.inst_addr_o, 32'hFFFF_FFFC);
    check("t5_wrap_req_addr", bus.imem_addr_o, 32'h0);
    step(0, 0, 0);
    check("t5_wrap_inst_addr", bus.inst_addr_o, 32'h0);

    // Randomized ack / hold / jump traffic.
    ack_mode = 1;
    a0 = accepts;
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(99, 0) < 30), 1'($urandom_range(99, 0) < 4), $urandom);
    end
    check("rand_progress", 32'((accepts - a0) >= 150), 32'h1);

    // Asynchronous reset while a request waits for its ack.
    ack_mode = 2;
    step(0, 0, 0);
    #2;
    rst_n = 1'b0;
    bus.imem_ack_i = 1'b0;
    bus.hold_i = 1'b0;
    bus.jump_en_i = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 0;
    for (int n = 0; n < 20 && accepts < 5; n++) step(0, 0, 0);
    check("t6_accepts", 32'(accepts), 32'h5);
    check("t6_cnt_five", bus.fetch_cnt_o, CNT_EN ? 32'h5 : 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_cnt_reset", bus.fetch_cnt_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
